// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, multi-cycle and taken-branch hazard control for a 5-stage pipeline
module pipe_hazard_ctrl #(
   parameter logic [6:0] LOAD_OPCODE  = 7'b0000011,
   parameter int         FLUSH_CYCLES = 2,
   parameter int         CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid_i,
   input  logic [4:0]           id_rs1_i,
   input  logic [4:0]           id_rs2_i,
   input  logic                 id_rs1_used_i,
   input  logic                 id_rs2_used_i,
   input  logic                 ex_valid_i,
   input  logic [6:0]           ex_opcode_i,
   input  logic [4:0]           ex_rd_i,
   input  logic                 ex_branch_taken_i,
   input  logic                 ex_busy_i,
   input  logic                 ex_done_i,
   output logic                 stall_o,
   output logic                 bubble_o,
   output logic                 hold_ex_o,
   output logic                 flush_o,
   output logic [1:0]           state_o,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o
);
   localparam logic [1:0] RUN        = 2'd0;
   localparam logic [1:0] MULTI      = 2'd1;
   localparam logic [1:0] FLUSH      = 2'd2;
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   logic [1:0]           r_state, w_next;
   logic [3:0]           r_fcnt, w_fcnt_next;
   logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
   logic                 w_load_use, w_taken, w_stall, w_bubble, w_hold, w_flush;
   assign w_load_use = ex_valid_i && (ex_opcode_i == LOAD_OPCODE) && (ex_rd_i != 5'd0) && id_valid_i &&
                       ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) || (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
   assign w_taken    = ex_valid_i && ex_branch_taken_i;
   // next state and raw controls; flush beats busy beats load-use, and MULTI ignores branches until done
   always_comb begin
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
      w_hold      = 1'b0;
      w_flush     = 1'b0;
      w_next      = r_state;
      w_fcnt_next = r_fcnt;
      if (r_state == FLUSH) begin
         w_flush     = 1'b1;
         w_bubble    = 1'b1;
         w_fcnt_next = (r_fcnt <= 4'd1) ? 4'd0 : r_fcnt - 4'd1;
         w_next      = (r_fcnt <= 4'd1) ? RUN : FLUSH;
      end else if (r_state == MULTI && !ex_done_i) begin
         w_stall = 1'b1;
         w_hold  = 1'b1;
      end else if ((r_state == MULTI) ? ex_branch_taken_i : w_taken) begin
         w_flush     = 1'b1;
         w_bubble    = 1'b1;
         w_next      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
         w_fcnt_next = (FLUSH_CYCLES > 1) ? FLUSH_LOAD : 4'd0;
      end else if (r_state == RUN && ex_valid_i && ex_busy_i) begin
         w_stall = 1'b1;
         w_hold  = 1'b1;
         w_next  = MULTI;
      end else begin
         w_next   = RUN;
         w_stall  = w_load_use;
         w_bubble = w_load_use;
      end
   end
   assign stall_o     = w_stall  && !rst;
   assign bubble_o    = w_bubble && !rst;
   assign hold_ex_o   = w_hold   && !rst;
   assign flush_o     = w_flush  && !rst;
   assign state_o     = r_state;
   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
   // state, flush down-counter and saturating event counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_fcnt      <= 4'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next;
         r_fcnt      <= w_fcnt_next;
         r_stall_cnt <= (stall_o && r_stall_cnt != '1) ? r_stall_cnt + 1'b1 : r_stall_cnt;
         r_flush_cnt <= (flush_o && r_flush_cnt != '1) ? r_flush_cnt + 1'b1 : r_flush_cnt;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   localparam logic [6:0] LD = 7'b0000011;
   typedef struct {
      string       tag;
      logic [3:0]  o;
      logic [1:0]  st;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid_i, id_rs1_used_i, id_rs2_used_i;
   logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
   logic        ex_valid_i, ex_branch_taken_i, ex_busy_i, ex_done_i;
   logic [6:0]  ex_opcode_i;
   logic        stall_o, bubble_o, hold_ex_o, flush_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o, flush_cnt_o;
   logic        s_stall, s_bubble, s_hold, s_flush;
   logic [1:0]  s_state;
   logic [3:0]  s_stall_cnt, s_flush_cnt;
   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] e_sc = 16'd0;
   logic [15:0] e_fc = 16'd0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .ex_valid_i(ex_valid_i),
      .ex_opcode_i(ex_opcode_i), .ex_rd_i(ex_rd_i), .ex_branch_taken_i(ex_branch_taken_i),
      .ex_busy_i(ex_busy_i), .ex_done_i(ex_done_i), .stall_o(stall_o), .bubble_o(bubble_o),
      .hold_ex_o(hold_ex_o), .flush_o(flush_o), .state_o(state_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));

   pipe_hazard_ctrl #(.CNT_WIDTH(4)) u_sat (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .ex_valid_i(ex_valid_i),
      .ex_opcode_i(ex_opcode_i), .ex_rd_i(ex_rd_i), .ex_branch_taken_i(ex_branch_taken_i),
      .ex_busy_i(ex_busy_i), .ex_done_i(ex_done_i), .stall_o(s_stall), .bubble_o(s_bubble),
      .hold_ex_o(s_hold), .flush_o(s_flush), .state_o(s_state),
      .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt));

   task automatic clr();
      id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
      ex_valid_i = 0; ex_opcode_i = 0; ex_rd_i = 0; ex_branch_taken_i = 0; ex_busy_i = 0; ex_done_i = 0;
   endtask

   task automatic load_use(input logic [4:0] rd);
      ex_valid_i = 1; ex_opcode_i = LD; ex_rd_i = rd; id_valid_i = 1; id_rs1_i = 5; id_rs1_used_i = 1;
   endtask

   // o = {stall, bubble, hold, flush} expected in the current cycle; st = expected registered state
   task automatic step(input string tag, input logic [3:0] o, input logic [1:0] st);
      exp_t e;
      logic [3:0] sat_sc, sat_fc;
      e.tag = tag; e.o = o; e.st = st; e.sc = e_sc; e.fc = e_fc;
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      sat_sc = (e.sc > 16'd15) ? 4'hF : e.sc[3:0];
      sat_fc = (e.fc > 16'd15) ? 4'hF : e.fc[3:0];
      checks++;
      assert ({stall_o, bubble_o, hold_ex_o, flush_o} === e.o) else begin
         failures++; $error("FAIL %s outs got=%b exp=%b", e.tag, {stall_o, bubble_o, hold_ex_o, flush_o}, e.o);
      end
      checks++;
      assert (state_o === e.st) else begin
         failures++; $error("FAIL %s state got=%0d exp=%0d", e.tag, state_o, e.st);
      end
      checks++;
      assert (stall_cnt_o === e.sc && flush_cnt_o === e.fc) else begin
         failures++; $error("FAIL %s cnt got=%0d/%0d exp=%0d/%0d", e.tag, stall_cnt_o, flush_cnt_o, e.sc, e.fc);
      end
      checks++;
      assert (s_stall_cnt === sat_sc && s_flush_cnt === sat_fc) else begin
         failures++; $error("FAIL %s satcnt got=%0d/%0d exp=%0d/%0d", e.tag, s_stall_cnt, s_flush_cnt, sat_sc, sat_fc);
      end
      checks++;
      assert (!(bubble_o && hold_ex_o)) else begin
         failures++; $error("FAIL %s bubble_hold got=11 exp=not both", e.tag);
      end
      if (rst) begin
         e_sc = 16'd0; e_fc = 16'd0;
      end else begin
         if (o[3]) e_sc = e_sc + 16'd1;
         if (o[0]) e_fc = e_fc + 16'd1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; clr();
      repeat (2) @(posedge clk);
      #1;
      ex_valid_i = 1; ex_branch_taken_i = 1; ex_busy_i = 1;
      step("rst_force", 4'b0000, 2'd0);
      rst = 0; clr();
      step("idle", 4'b0000, 2'd0);
      load_use(5);
      step("lu_rs1", 4'b1100, 2'd0);
      clr();
      step("lu_after", 4'b0000, 2'd0);
      load_use(0);
      step("lu_x0", 4'b0000, 2'd0);
      load_use(5); id_rs1_used_i = 0;
      step("lu_unused", 4'b0000, 2'd0);
      id_rs2_i = 5; id_rs2_used_i = 1;
      step("lu_rs2", 4'b1100, 2'd0);
      ex_opcode_i = 7'b0110011;
      step("lu_notload", 4'b0000, 2'd0);
      clr(); ex_valid_i = 1; ex_branch_taken_i = 1;
      step("br_take", 4'b0101, 2'd0);
      clr(); load_use(5); ex_busy_i = 1;
      step("br_flush", 4'b0101, 2'd2);
      clr();
      step("br_done", 4'b0000, 2'd0);
      ex_valid_i = 1; ex_branch_taken_i = 1; ex_valid_i = 0;
      step("br_invalid", 4'b0000, 2'd0);
      clr(); ex_valid_i = 1; ex_busy_i = 1;
      step("mc_start", 4'b1010, 2'd0);
      ex_branch_taken_i = 1;
      step("mc_wait1", 4'b1010, 2'd1);
      step("mc_wait2", 4'b1010, 2'd1);
      step("mc_wait3", 4'b1010, 2'd1);
      ex_branch_taken_i = 0; ex_done_i = 1;
      step("mc_done", 4'b0000, 2'd1);
      clr();
      step("mc_back", 4'b0000, 2'd0);
      ex_valid_i = 1; ex_busy_i = 1;
      step("mcb_start", 4'b1010, 2'd0);
      ex_done_i = 1; ex_branch_taken_i = 1;
      step("mcb_done", 4'b0101, 2'd1);
      clr();
      step("mcb_flush", 4'b0101, 2'd2);
      step("mcb_back", 4'b0000, 2'd0);
      load_use(5); ex_busy_i = 1;
      step("mcl_start", 4'b1010, 2'd0);
      ex_done_i = 1;
      step("mcl_done_lu", 4'b1100, 2'd1);
      clr();
      step("mcl_back", 4'b0000, 2'd0);
      load_use(5); ex_busy_i = 1; ex_branch_taken_i = 1;
      step("sim_all", 4'b0101, 2'd0);
      clr();
      step("sim_flush", 4'b0101, 2'd2);
      step("sim_back", 4'b0000, 2'd0);
      ex_valid_i = 1; ex_busy_i = 1;
      step("rm_start", 4'b1010, 2'd0);
      step("rm_wait1", 4'b1010, 2'd1);
      rst = 1;
      step("rm_rst", 4'b0000, 2'd1);
      rst = 0; clr();
      step("rm_after", 4'b0000, 2'd0);
      ex_valid_i = 1; ex_branch_taken_i = 1;
      step("rf_take", 4'b0101, 2'd0);
      clr(); rst = 1;
      step("rf_rst", 4'b0000, 2'd2);
      rst = 0;
      step("rf_after", 4'b0000, 2'd0);
      ex_valid_i = 1; ex_busy_i = 1;
      for (int i = 0; i < 20; i++) step("sat_stall", 4'b1010, (i == 0) ? 2'd0 : 2'd1);
      ex_done_i = 1;
      step("sat_done", 4'b0000, 2'd1);
      clr();
      step("sat_end", 4'b0000, 2'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter LOAD_OPCODE, default 7'b0000011, opcode that marks a load in EX.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..15, cycles flush_o stays asserted per taken branch.
REQ-003 Parameter CNT_WIDTH, default 16, width of the event counters.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 id_valid_i  in  1  ID stage holds a real instruction.
REQ-007 id_rs1_i, id_rs2_i  in  5 each  source register addresses in ID.
REQ-008 id_rs1_used_i, id_rs2_used_i  in  1 each  the ID instruction reads that source.
REQ-009 ex_valid_i  in  1  EX stage (ID/EX register output) holds a real instruction.
REQ-010 ex_opcode_i  in  7  opcode in EX.
REQ-011 ex_rd_i  in  5  destination register in EX.
REQ-012 ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
REQ-013 ex_busy_i  in  1  EX instruction needs a multi-cycle unit.
REQ-014 ex_done_i  in  1  multi-cycle unit result is ready this cycle.
REQ-015 stall_o  out  1  hold PC and IF/ID register.
REQ-016 bubble_o  out  1  load a NOP (valid=0) into the ID/EX register.
REQ-017 hold_ex_o  out  1  hold the ID/EX register contents.
REQ-018 flush_o  out  1  invalidate the IF/ID register.
REQ-019 state_o  out  2  FSM state: 0 RUN, 1 MULTI, 2 FLUSH.
REQ-020 stall_cnt_o, flush_cnt_o  out  CNT_WIDTH each  event counters.

Function
REQ-021 The FSM SHALL have the states RUN, MULTI and FLUSH, plus a 4-bit flush down-counter.
REQ-022 Load-use is true when ex_valid_i, ex_opcode_i==LOAD_OPCODE, ex_rd_i!=0, id_valid_i, and either (id_rs1_used_i and id_rs1_i==ex_rd_i) or (id_rs2_used_i and id_rs2_i==ex_rd_i).
REQ-023 Taken is true when ex_valid_i and ex_branch_taken_i are both high.
REQ-024 In RUN, if Taken holds: flush_o=1 and bubble_o=1 in that same cycle (combinational). If FLUSH_CYCLES>1, the next state is FLUSH with the counter loaded to FLUSH_CYCLES-1. Otherwise the state stays RUN.
REQ-025 In RUN, if Taken is false and ex_valid_i and ex_busy_i hold: stall_o=1 and hold_ex_o=1 in that same cycle, and the next state is MULTI.
REQ-026 In RUN, if neither Taken nor the busy condition holds but Load-use holds: stall_o=1 and bubble_o=1 for that cycle only, and the state stays RUN.
REQ-027 Priority in RUN SHALL be Taken, then busy, then Load-use; a lower-priority condition SHALL produce no output while a higher one is active.
REQ-028 In MULTI, while ex_done_i=0: stall_o=1 and hold_ex_o=1, and the state stays MULTI. ex_branch_taken_i SHALL be ignored.
REQ-029 In MULTI, the cycle ex_done_i=1: stall_o=0 and hold_ex_o=0. Then:
- if ex_branch_taken_i=1: apply the REQ-024 outputs and transition.
- otherwise: the next state is RUN, and Load-use is evaluated as in RUN that cycle.
REQ-030 In FLUSH: flush_o=1 and bubble_o=1, and the counter decrements each cycle. When the counter reads 1, the next state is RUN. All other inputs SHALL be ignored.
REQ-031 bubble_o and hold_ex_o SHALL never both be 1 in the same cycle.
REQ-032 stall_cnt_o SHALL increment on every cycle with stall_o=1 and saturate at all-ones.
REQ-033 flush_cnt_o SHALL increment on every cycle with flush_o=1 and saturate at all-ones.
REQ-034 state_o SHALL be the registered FSM state. All other outputs are combinational from the state and the inputs.

Reset
REQ-035 When rst=1 at a clock edge: state becomes RUN, the flush down-counter becomes 0, and stall_cnt_o and flush_cnt_o become 0.
REQ-036 While rst=1: stall_o, bubble_o, hold_ex_o and flush_o SHALL all be forced to 0.
REQ-037 Reset asserted in MULTI or FLUSH SHALL abort the operation; RUN is entered on the next edge with no residual flush or stall.

Verification
REQ-038 Load-use: a load to x5 in EX, and ID reads rs1=x5 with rs1_used=1. Required: stall_o=1 and bubble_o=1 for exactly 1 cycle, and stall_cnt_o=1. The same case with ex_rd=x0 SHALL produce no stall.
REQ-039 Branch: Taken pulsed for 1 cycle with FLUSH_CYCLES=2. Required: flush_o=1 for 2 consecutive cycles, state_o goes 0,2,0, and flush_cnt_o=2.
REQ-040 Multi-cycle: ex_busy_i=1, then ex_done_i=1 arrives 4 cycles later. Required: stall_o=1 and hold_ex_o=1 for 4 cycles, 0 on the done cycle, and state_o=1 during the wait.
REQ-041 Simultaneous events: Taken, busy and Load-use all true in the same cycle. Required: flush_o=1, stall_o=0, and the next state is FLUSH.
REQ-042 Reset mid-operation: rst=1 during the second cycle of MULTI. Required: all outputs 0 that cycle, state_o=0 next cycle, and both counters 0.
REQ-043 Saturation: with CNT_WIDTH=4, hold stall asserted for 20 cycles. Required: stall_cnt_o stays at 15.
